// File: rtl/matrix_scan_controller.sv
// 5x7 LED matrix scan sequencer with debounced level commit; CRITICAL_BLINK_EN adds critical-level blink.
// Outputs registered one cycle behind scan state; free-running, no backpressure.
module matrix_scan_controller #(
  parameter int DWELL         = 1000,
  parameter int BLANK         = 16,
  parameter int STABLE_FRAMES = 4,
  parameter int BLINK_FRAMES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sensor_level,
  output logic [1:0] level_code,
  input  logic [6:0] pat_outer,
  input  logic [6:0] pat_inner,
  output logic [4:0] col_n,
  output logic [6:0] row_n,
  output logic       frame_tick
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam int MAXP = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int SW   = $clog2(STABLE_FRAMES + 1);

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK - 1);
  localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);

  if (DWELL < 1) begin : g_err_dwell
    $error("DWELL must be >= 1");
  end
  if (BLANK < 1) begin : g_err_blank
    $error("BLANK must be >= 1");
  end
  if (STABLE_FRAMES < 1) begin : g_err_stable
    $error("STABLE_FRAMES must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : g_err_blink
    $error("BLINK_FRAMES must be >= 1");
  end

  logic [0:0]    state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    cand_q, cand_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [1:0]    level_q, level_d;
  logic [4:0]    col_n_q, col_n_d;
  logic [6:0]    row_n_q, row_n_d;
  logic          tick_q, tick_d;
  logic          tick_now;
  logic          blink_on;

  // Scan state leads the registered outputs by one cycle.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    phase_d  = phase_q + 1'b1;
    tick_now = (state_q == ST_BLANK) && (col_q == 3'd0) && (phase_q == '0);
    if (state_q == ST_BLANK) begin
      if (phase_q == BLANK_LAST) begin
        state_d = ST_DRIVE;
        phase_d = '0;
      end
    end else begin
      if (phase_q == DWELL_LAST) begin
        state_d = ST_BLANK;
        phase_d = '0;
        col_d   = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
      end
    end
  end

  always_comb begin
    tick_d  = tick_now;
    col_n_d = 5'h1F;
    row_n_d = row_n_q;
    if (state_q == ST_BLANK) begin
      row_n_d = 7'h7F;
    end else begin
      col_n_d = ~(5'b00001 << col_q);
      if (phase_q == '0) begin
        if ((col_q == 3'd0) || (col_q == 3'd4)) begin
          row_n_d = ~pat_outer;
        end else if (blink_on) begin
          row_n_d = ~pat_inner;
        end else begin
          row_n_d = 7'h7F;
        end
      end
    end
  end

  // Debounce runs only at frame start so a frame never mixes two levels.
  always_comb begin
    sync1_d = sensor_level;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_now) begin
      if (sync2_q == cand_q) begin
        if (cnt_q != STABLE_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cand_d = sync2_q;
        cnt_d  = SW'(1);
      end
      if (cnt_d == STABLE_MAX) begin
        level_d = cand_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      col_q   <= 3'd0;
      phase_q <= '0;
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      cand_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 2'b00;
      col_n_q <= 5'h1F;
      row_n_q <= 7'h7F;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      col_n_q <= col_n_d;
      row_n_q <= row_n_d;
      tick_q  <= tick_d;
    end
  end

`ifdef CRITICAL_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  // Uses level_d so a commit and the blink update agree on the same tick.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (tick_now) begin
      if (level_d != 2'b00) begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = BW'(1);
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on = blink_on_q;
`else
  assign blink_on = 1'b1;
`endif

  assign level_code = level_q;
  assign col_n      = col_n_q;
  assign row_n      = row_n_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/matrix_scan_controller.md
# matrix_scan_controller

Sequencer for the CPLD kit's 5×7 LED matrix water-level display. It debounces the sensor level code and feeds the committed level to the combinational level-to-pattern decoder. It reads back the decoder's outer-column and inner-column row patterns and time-multiplexes them onto the five column strobes and seven row lines. Blanking gaps between columns prevent ghosting, and an optional blink flags the critical level.

## Interface
- `DWELL`, default 1000: cycles each column is driven; must be ≥ 1.
- `BLANK`, default 16: all-off cycles before each column; must be ≥ 1.
- `STABLE_FRAMES`, default 4: consecutive identical frame samples required to commit a new level; must be ≥ 1.
- `BLINK_FRAMES`, default 32: frames per blink half-period. Used only with `CRITICAL_BLINK_EN`.
- `clk` input, 1 bit: the only clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `sensor_level` input, 2 bits: raw water-level code, asynchronous to `clk`. 00 critical, 01 low, 10 mid, 11 high.
- `level_code` output, 2 bits: committed level, driven to the decoder's data input.
- `pat_outer` input, 7 bits: decoder pattern for columns 0 and 4. Bit i is row i, 1 = lit.
- `pat_inner` input, 7 bits: decoder pattern for columns 1, 2 and 3.
- `col_n` output, 5 bits: column strobes, active-low, at most one low at a time.
- `row_n` output, 7 bits: row drives, active-low.
- `frame_tick` output, 1 bit: one-cycle pulse at each frame start.

## Operation
- **Input sync:** `sensor_level` passes through a 2-flop synchronizer. Only the synchronized value is used.
- **Scan FSM:**
  - States are BLANK and DRIVE. Column index `c` runs 0..4. Each state has a phase counter.
  - BLANK: `col_n` = 11111 and `row_n` = 7F for `BLANK` cycles, then go to DRIVE.
  - DRIVE: `col_n[c]` = 0 for `DWELL` cycles, then go to BLANK with `c` ← `c`+1. After column 4, `c` wraps to 0.
  - Frame length is 5 × (`BLANK` + `DWELL`) cycles.
- **Row load:** on the BLANK→DRIVE edge, `row_n` ← ~`pat_outer` for c ∈ {0,4} and ~`pat_inner` for c ∈ {1,2,3}. `row_n` is held for the whole DRIVE phase; patterns are never re-sampled mid-column.
- **Frame tick:** `frame_tick` = 1 in the first BLANK cycle of column 0. This includes the first cycle after reset.
- **Debounce:** evaluated only in `frame_tick` cycles, on the synchronized sample `s`.
  - If `s` == `cand`, then `cnt` ← min(`cnt`+1, `STABLE_FRAMES`).
  - Otherwise `cand` ← `s` and `cnt` ← 1.
  - `level_code` ← `cand` on the tick where the new `cnt` equals `STABLE_FRAMES`.
  - `level_code` therefore changes only at frame start, so no frame mixes two levels.
- **Parameter errors:** an out-of-range parameter value is an elaboration error.

## Timing
- **Reset values:** `col_n` = 11111, `row_n` = 7F, `level_code` = 00, `frame_tick` = 0.
- **Internal state after reset:** FSM in BLANK with `c` = 0 and phase counter 0; `cand` = 00, `cnt` = 0, synchronizer = 00, blink phase = on.
- **First cycle after reset release:** this is BLANK cycle 0 of column 0, and `frame_tick` = 1.
- **Outputs are registered:**
  - `col_n[0]` goes low at cycle `BLANK` after release.
  - It returns high at cycle `BLANK`+`DWELL`.
- **Decoder path:** `pat_*` must settle within one cycle of `level_code` changing. The earliest row load after a level change is `BLANK` ≥ 1 cycles later.
- **Debounce latency:** a level held steady from before tick k is committed at tick k+`STABLE_FRAMES`−1.
  - A glitch shorter than one frame interval is ignored unless it happens to be sampled on a tick.
  - A glitch sampled on a tick resets the count.
- **Reset mid-frame:** on the next edge all state returns to reset values. No partial column is completed.
- **Simultaneous commit and blink update at one tick:** the blink rule uses the newly committed value.

## Configuration
- **`CRITICAL_BLINK_EN` defined:**
  - While `level_code` == 00, a frame counter toggles a blink phase every `BLINK_FRAMES` frames.
  - In the off phase, columns 1–3 load `row_n` = 7F. Their `col_n` still strobes and timing is unchanged. Columns 0 and 4 are unaffected.
  - When `level_code` != 00, the counter clears and the phase is forced on.
- **Not defined:**
  - No blink logic is synthesized.
  - The display is static at every level.

## Test plan
- **Reset, then hold `sensor_level` = 11 with `BLANK`=2, `DWELL`=4:**
  - `frame_tick` is 1 in cycle 0.
  - `col_n` = 11110 during cycles 2–5.
  - `col_n` = 11101 during cycles 8–11.
  - `frame_tick` repeats every 30 cycles.
- **Level commit with `STABLE_FRAMES`=4:**
  - After reset, drive `sensor_level` = 10 before the first tick.
  - `level_code` stays 00 through tick 3 and becomes 10 at tick 4.
  - Row loads before tick 4 use the level-00 patterns; loads after tick 4 use the level-10 patterns.
- **Glitch rejection:**
  - Hold 01 until committed, then present 11 on exactly one tick and return to 01.
  - `level_code` stays 01 and never becomes 11.
- **Row mapping:**
  - Force `pat_outer` = 7F and `pat_inner` = 03.
  - `row_n` = 00 during columns 0 and 4.
  - `row_n` = 7C during columns 1–3.
  - `row_n` = 7F in every BLANK cycle.
- **Blink with `CRITICAL_BLINK_EN`, `BLINK_FRAMES`=2, level 00:**
  - Inner-column `row_n` = ~`pat_inner` for 2 frames, then 7F for 2 frames, repeating.
  - Outer columns stay constant throughout.
  - When the level commits to 01, inner-column `row_n` reverts to ~`pat_inner` from that frame on.
- **Mid-DRIVE reset:**
  - Assert `rst` for one cycle during column 2.
  - On the next edge, `col_n` = 11111, `row_n` = 7F and `level_code` = 00.
  - Scanning restarts at column 0 with `frame_tick` = 1.
